// File: rtl/seqdet_pkg.sv
// Shared types and constants for the serial pattern counter.
package seqdet_pkg;

  localparam int unsigned COUNT_W             = 8;
  localparam int unsigned DEFAULT_PATTERN_LEN = 4;
  localparam logic [3:0]  DEFAULT_PATTERN     = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Increment that sticks at all-ones.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == '1) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/sequence_pattern_counter_if.sv
// Control inputs and status outputs of the pattern counter.
interface sequence_pattern_counter_if;
  import seqdet_pkg::*;

  logic               enable;
  logic               bit_in;
  logic               bit_valid;
  logic               clear;
  logic [COUNT_W-1:0] pattern_count;
  logic               match_pulse;
  logic [COUNT_W-1:0] bits_seen;
  logic               stream_done;

  modport master (
    output enable, bit_in, bit_valid, clear,
    input  pattern_count, match_pulse, bits_seen, stream_done
  );

  modport slave (
    input  enable, bit_in, bit_valid, clear,
    output pattern_count, match_pulse, bits_seen, stream_done
  );

endinterface

// File: rtl/seqdet_window.sv
// Shift window with fill counter; hit flags a completed pattern on the shifting edge.
module seqdet_window
  import seqdet_pkg::*;
#(
  parameter int unsigned     LEN     = DEFAULT_PATTERN_LEN,
  parameter logic [LEN-1:0]  PATTERN = LEN'(DEFAULT_PATTERN),
  parameter bit              OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic shift,
  input  logic flush,
  input  logic bit_in,
  output logic hit
);

  localparam int unsigned FILL_W = 4;

  logic [LEN-1:0]    window;
  logic [LEN-1:0]    window_nxt;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_nxt;

  assign window_nxt = {window[LEN-2:0], bit_in};
  assign fill_nxt   = (fill == FILL_W'(LEN)) ? fill : fill + FILL_W'(1);
  assign hit        = shift && (fill_nxt == FILL_W'(LEN)) && (window_nxt == PATTERN);

  // Window/fill update; non-overlapping mode restarts the fill after a hit.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      window <= '0;
      fill   <= '0;
    end else if (shift) begin
      window <= window_nxt;
      fill   <= (hit && !OVERLAP) ? '0 : fill_nxt;
    end
  end

endmodule

// File: rtl/sequence_pattern_counter.sv
// Counts occurrences of a serial bit pattern over a bounded or unbounded run.
module sequence_pattern_counter
  import seqdet_pkg::*;
#(
  parameter int unsigned             PATTERN_LEN = DEFAULT_PATTERN_LEN,
  parameter logic [PATTERN_LEN-1:0]  PATTERN     = PATTERN_LEN'(DEFAULT_PATTERN),
  parameter bit                      OVERLAP     = 1'b1,
  parameter int unsigned             STREAM_LEN  = 16
) (
  input  logic                     clock_100Mhz,
  input  logic                     reset,
  sequence_pattern_counter_if.slave bus
);

  localparam bit                 BOUNDED  = (STREAM_LEN != 0);
  localparam logic [COUNT_W-1:0] LAST_IDX = COUNT_W'((STREAM_LEN == 0) ? 0 : STREAM_LEN - 1);

  state_t             state;
  logic [COUNT_W-1:0] pattern_count;
  logic [COUNT_W-1:0] bits_seen;
  logic               match_pulse;
  logic               stream_done;
  logic               accept;
  logic               hit;

  assign accept = (state == ST_RUN) && bus.bit_valid && !bus.clear;

  seqdet_window #(
    .LEN     (PATTERN_LEN),
    .PATTERN (PATTERN),
    .OVERLAP (OVERLAP)
  ) u_window (
    .clk    (clock_100Mhz),
    .rst    (reset),
    .shift  (accept),
    .flush  (bus.clear),
    .bit_in (bus.bit_in),
    .hit    (hit)
  );

  // Control FSM with registered counters and status outputs.
  always_ff @(posedge clock_100Mhz) begin
    if (reset || bus.clear) begin
      state         <= ST_IDLE;
      pattern_count <= '0;
      bits_seen     <= '0;
      match_pulse   <= 1'b0;
      stream_done   <= 1'b0;
    end else begin
      match_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.enable) state <= ST_RUN;
        end
        ST_RUN: begin
          if (bus.bit_valid) begin
            bits_seen <= sat_inc(bits_seen);
            if (hit) begin
              match_pulse   <= 1'b1;
              pattern_count <= sat_inc(pattern_count);
            end
            if (BOUNDED && (bits_seen == LAST_IDX)) begin
              state       <= ST_DONE;
              stream_done <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          stream_done <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.pattern_count = pattern_count;
  assign bus.bits_seen     = bits_seen;
  assign bus.match_pulse   = match_pulse;
  assign bus.stream_done   = stream_done;

endmodule

// File: tb/tb_sequence_pattern_counter.sv
// Bench: three configurations driven in lockstep, checked against a bit-history model.
module tb_sequence_pattern_counter;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;
  int tally_c = 0;

  sequence_pattern_counter_if if_a();
  sequence_pattern_counter_if if_b();
  sequence_pattern_counter_if if_c();

  sequence_pattern_counter dut_a (
    .clock_100Mhz (clk),
    .reset        (rst),
    .bus          (if_a.slave)
  );

  sequence_pattern_counter #(.OVERLAP(1'b0)) dut_b (
    .clock_100Mhz (clk),
    .reset        (rst),
    .bus          (if_b.slave)
  );

  sequence_pattern_counter #(.PATTERN(4'b1111), .STREAM_LEN(0)) dut_c (
    .clock_100Mhz (clk),
    .reset        (rst),
    .bus          (if_c.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: full history of accepted bits per configuration.
  int cfg_pat  [3] = '{11, 11, 15};
  bit cfg_ovl  [3] = '{1'b1, 1'b0, 1'b1};
  int cfg_slen [3] = '{16, 16, 0};

  bit hist   [3][0:1023];
  int hlen   [3];
  int seg    [3];
  int m_st   [3];   // 0 idle, 1 running, 2 finished
  int m_cnt  [3];
  int m_seen [3];
  bit m_pulse[3];

  function automatic bit window_match(int k);
    int v;
    if (hlen[k] - seg[k] < 4) return 1'b0;
    v = 0;
    for (int i = 0; i < 4; i++) v = v * 2 + int'(hist[k][hlen[k] - 4 + i]);
    return v == cfg_pat[k];
  endfunction

  task automatic model_edge(input int k, input bit en, input bit bv, input bit b,
                            input bit clr, input bit r);
    if (r || clr) begin
      m_st[k] = 0; m_cnt[k] = 0; m_seen[k] = 0; m_pulse[k] = 1'b0;
      hlen[k] = 0; seg[k] = 0;
    end else begin
      m_pulse[k] = 1'b0;
      if (m_st[k] == 0) begin
        if (en) m_st[k] = 1;
      end else if (m_st[k] == 1 && bv) begin
        if (m_seen[k] < 255) m_seen[k]++;
        if (hlen[k] < 1024) begin
          hist[k][hlen[k]] = b;
          hlen[k]++;
        end
        if (window_match(k)) begin
          m_pulse[k] = 1'b1;
          if (m_cnt[k] < 255) m_cnt[k]++;
          if (!cfg_ovl[k]) seg[k] = hlen[k];
        end
        if (cfg_slen[k] != 0 && m_seen[k] == cfg_slen[k]) m_st[k] = 2;
      end
    end
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  task automatic check_dut(input int k, input logic [7:0] c, input logic [7:0] s,
                           input logic p, input logic d);
    chk("pattern_count", k, 32'(c), 32'(m_cnt[k]));
    chk("bits_seen",     k, 32'(s), 32'(m_seen[k]));
    chk("match_pulse",   k, 32'(p), 32'(m_pulse[k]));
    chk("stream_done",   k, 32'(d), 32'(m_st[k] == 2));
  endtask

  task automatic drive(input bit en, input bit bv, input bit b, input bit clr, input bit r);
    rst = r;
    if_a.enable = en; if_a.bit_valid = bv; if_a.bit_in = b; if_a.clear = clr;
    if_b.enable = en; if_b.bit_valid = bv; if_b.bit_in = b; if_b.clear = clr;
    if_c.enable = en; if_c.bit_valid = bv; if_c.bit_in = b; if_c.clear = clr;
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge, check 1 unit later.
  task automatic step(input bit en, input bit bv, input bit b, input bit clr, input bit r);
    @(negedge clk);
    drive(en, bv, b, clr, r);
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k, en, bv, b, clr, r);
    #1;
    if (if_c.match_pulse === 1'b1) tally_c++;
    check_dut(0, if_a.pattern_count, if_a.bits_seen, if_a.match_pulse, if_a.stream_done);
    check_dut(1, if_b.pattern_count, if_b.bits_seen, if_b.match_pulse, if_b.stream_done);
    check_dut(2, if_c.pattern_count, if_c.bits_seen, if_c.match_pulse, if_c.stream_done);
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    logic [31:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, 1'b1, v[i], 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) model_edge(k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Stream 1011011, overlapping vs non-overlapping
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(32'b1011011, 7);
    chk("s_ovl_count",     0, 32'(if_a.pattern_count), 32'd2);
    chk("s_ovl_seen",      0, 32'(if_a.bits_seen),     32'd7);
    chk("s_ovl_done",      0, 32'(if_a.stream_done),   32'd0);
    chk("s_novl_count",    1, 32'(if_b.pattern_count), 32'd1);

    // 16-bit bounded run plus an ignored 17th strobe
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(32'hBBBB, 16);
    chk("s16_done",        0, 32'(if_a.stream_done),   32'd1);
    send_bits(32'b1, 1);
    chk("s16_count",       0, 32'(if_a.pattern_count), 32'd4);
    chk("s16_seen",        0, 32'(if_a.bits_seen),     32'd16);
    chk("s16_done_hold",   0, 32'(if_a.stream_done),   32'd1);

    // Clear with a concurrent strobe drops that bit
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(32'b101, 3);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("clr_seen",        0, 32'(if_a.bits_seen),     32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(32'b1011, 4);
    chk("clr_count",       0, 32'(if_a.pattern_count), 32'd1);

    // Reset after three bits discards the partial match; idle until enable
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_idle_seen",   0, 32'(if_a.bits_seen),     32'd0);
    chk("rst_idle_count",  0, 32'(if_a.pattern_count), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_rerun_count", 0, 32'(if_a.pattern_count), 32'd0);
    chk("rst_rerun_seen",  0, 32'(if_a.bits_seen),     32'd1);

    // 300 ones into the all-ones, unbounded config: count saturates
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tally_c = 0;
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sat_pulses",      2, 32'(tally_c),            32'd297);
    chk("sat_count",       2, 32'(if_c.pattern_count), 32'd255);
    chk("sat_seen",        2, 32'(if_c.bits_seen),     32'd255);

    // Randomized traffic with occasional clear and reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 59) == 0, $urandom_range(0, 119) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequence_pattern_counter.md
SEQUENCE_PATTERN_COUNTER -- requirements
Module: sequence_pattern_counter

Interface
REQ-001 Parameter PATTERN_LEN, default 4: pattern length in bits, legal range 2..8.
REQ-002 Parameter PATTERN, default 4'b1011: target pattern. The MSB is the first bit received.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-004 Parameter STREAM_LEN, default 16: number of bits accepted per run, range 1..255. 0 = unbounded.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 clock_100Mhz  in  1  system clock; all state changes on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 enable  in  1  level; IDLE->RUN start request.
REQ-009 bit_in  in  1  serial data bit (e.g. BRAM douta).
REQ-010 bit_valid  in  1  single-cycle strobe qualifying bit_in (e.g. one-second enable).
REQ-011 clear  in  1  synchronous restart of the run; does not reset parameters.
REQ-012 pattern_count  out  8  number of matches, saturating.
REQ-013 match_pulse  out  1  one-cycle pulse per match.
REQ-014 bits_seen  out  8  number of bits accepted in the current run.
REQ-015 stream_done  out  1  level; high while the FSM is in DONE.

Function
REQ-016 Control FSM states: IDLE, RUN, DONE.
REQ-017 IDLE->RUN on the edge where enable=1. bit_valid is ignored while in IDLE.
REQ-018 In RUN, a bit is accepted only on cycles with bit_valid=1 and clear=0.
REQ-019 RUN->DONE on the edge that accepts bit number STREAM_LEN. With STREAM_LEN=0, DONE is never entered.
REQ-020 DONE is held until clear or reset. bit_valid is ignored in DONE and no outputs change.
REQ-021 Each accepted bit shifts into a PATTERN_LEN-bit window (new bit at LSB). The fill counter increments, saturating at PATTERN_LEN.
REQ-022 Match condition: fill counter == PATTERN_LEN and the updated window == PATTERN, both evaluated on the same accepting edge.
REQ-023 Latency: match_pulse is registered. It goes high for exactly one cycle starting at the edge that accepts the completing bit. pattern_count updates at the same edge.
REQ-024 OVERLAP=1: the window and fill counter are kept after a match, so 1011011 yields 2 matches.
REQ-025 OVERLAP=0: on a match the fill counter is zeroed (window contents become don't-care), so 1011011 yields 1 match.
REQ-026 pattern_count saturates at 255. A match at 255 still pulses match_pulse, but the count holds.
REQ-027 bits_seen increments per accepted bit and saturates at 255 (relevant only for unbounded runs).
REQ-028 clear has priority over bit_valid in the same cycle. Next edge: pattern_count, bits_seen, window and fill counter are 0, match_pulse is 0, state is IDLE.
REQ-029 enable falling during RUN has no effect. Only clear or reset leave RUN early.
REQ-030 reset has priority over clear, enable and bit_valid.

Reset
REQ-031 On reset: state=IDLE, pattern_count=0, bits_seen=0, match_pulse=0, stream_done=0, window=0, fill counter=0.
REQ-032 Reset asserted mid-run discards any partial match. The next run starts with an empty window.
REQ-033 All outputs are registered. No output depends combinationally on any input.

Structure
REQ-034 A shared package seqdet_pkg holds:
- the FSM state enumeration (IDLE, RUN, DONE);
- the count width constant (8);
- the default pattern constant.
REQ-035 One sub-module, seqdet_window, holds the shift window, fill counter and match compare (inputs: shift, flush, bit; output: hit). The top level holds the FSM, counters and output registers.

Verification
REQ-036 Default parameters, enable=1, stream 1011011 on bit_valid strobes -> match_pulse on bits 4 and 7; pattern_count=2; bits_seen=7; stream_done=0.
REQ-037 OVERLAP=0, same stream -> a single match_pulse on bit 4; pattern_count=1.
REQ-038 STREAM_LEN=16, stream 1011 repeated 4 times, then a 17th strobe with bit 1 -> pattern_count=4; stream_done=1 after bit 16; bits_seen=16; 17th bit has no effect.
REQ-039 PATTERN=4'b1111, STREAM_LEN=0, 300 strobes of bit 1 -> 297 match_pulses; pattern_count stops at 255.
REQ-040 Stream 101 then clear asserted together with a bit_valid carrying 1, then 1011 -> the clear cycle bit is dropped; first match on the 4th post-clear bit after re-enable; pattern_count=1.
REQ-041 reset pulsed one cycle after the bit_valid of bit 3 of 1011, then 1 -> no match; all outputs at reset values; stays in IDLE until enable.
